// File: rtl/zap_page_walker.sv
// zap_page_walker: multi-channel ARMv5 short-descriptor page-table walker.
// Round-robin arbitration over NUM_CH requestors, one walk at a time,
// descriptor fetches over a private Wishbone read master.
module zap_page_walker #(
    parameter  int NUM_CH  = 2,
    parameter  int TIMEOUT = 255,
    parameter  int FINE_EN = 1,
    localparam int CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_mmu_en,
    input  logic [31:0]          i_baddr,
    input  logic [NUM_CH-1:0]    i_walk_req,
    input  logic [NUM_CH*32-1:0] i_walk_va,
    output logic [NUM_CH-1:0]    o_walk_done,
    output logic                 o_fault,
    output logic [7:0]           o_fsr,
    output logic [31:0]          o_far,
    output logic [3:0]           o_tlb_wen,
    output logic [CHW-1:0]       o_tlb_ch,
    output logic [31:0]          o_tlb_va,
    output logic [31:0]          o_tlb_desc,
    output logic [3:0]           o_tlb_dac,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    output logic                 o_wb_wen,
    output logic [3:0]           o_wb_sel,
    output logic [31:0]          o_wb_adr,
    input  logic [31:0]          i_wb_dat,
    input  logic                 i_wb_ack,
    input  logic                 i_wb_err
);
    typedef enum logic [2:0] {IDLE, L1_REQ, L1_DEC, L2_REQ, L2_DEC, DONE} state_t;

    // Last counter value before a hung fetch is declared a bus error.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t              state_q;
    logic [CHW-1:0]      ch_q, rr_q;
    logic [31:0]         va_q, desc_q, adr_q, far_q;
    logic [3:0]          dac_q, wen_q, sel_q;
    logic                fine_q, cyc_q, stb_q, fault_q;
    logic [7:0]          fsr_q;
    logic [15:0]         cnt_q;
    logic [NUM_CH-1:0]   done_q;

    logic [NUM_CH-1:0][31:0] va_arr;
    logic                    gnt_vld;
    logic [CHW-1:0]          gnt_ch;
    logic [CHW:0]            idx;
    logic                    unused_baddr;

    assign va_arr       = i_walk_va;
    assign unused_baddr = ^i_baddr[13:0];

    // Round-robin pick: first requester at or after rr_q (descending scan so the
    // smallest offset from the pointer wins).
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        idx     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = {1'b0, rr_q} + (CHW+1)'(i);
            if (idx >= (CHW+1)'(NUM_CH)) idx = idx - (CHW+1)'(NUM_CH);
            if (i_walk_req[idx[CHW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_ch  = idx[CHW-1:0];
            end
        end
    end

    // Walk FSM; every output is a register, pulses clear by default each cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            ch_q    <= '0;
            rr_q    <= '0;
            va_q    <= '0;
            desc_q  <= '0;
            adr_q   <= '0;
            far_q   <= '0;
            dac_q   <= '0;
            wen_q   <= '0;
            sel_q   <= '0;
            fine_q  <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            fault_q <= 1'b0;
            fsr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= '0;
        end else begin
            done_q  <= '0;
            wen_q   <= '0;
            fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_mmu_en && gnt_vld) begin
                        ch_q    <= gnt_ch;
                        va_q    <= va_arr[gnt_ch];
                        adr_q   <= {i_baddr[31:14], va_arr[gnt_ch][31:20], 2'b00};
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        sel_q   <= 4'hF;
                        cnt_q   <= '0;
                        state_q <= L1_REQ;
                    end
                end
                L1_REQ, L2_REQ: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (i_wb_ack) begin
                        cyc_q  <= 1'b0;
                        stb_q  <= 1'b0;
                        sel_q  <= '0;
                        desc_q <= i_wb_dat;
                        // TLB write is decided on the ack edge so it lands in the *_DEC cycle.
                        if (state_q == L1_REQ) begin
                            dac_q    <= i_wb_dat[8:5];
                            fine_q   <= (i_wb_dat[1:0] == 2'b11);
                            wen_q[0] <= (i_wb_dat[1:0] == 2'b10);
                            state_q  <= L1_DEC;
                        end else begin
                            wen_q[1] <= (i_wb_dat[1:0] == 2'b01);
                            wen_q[2] <= (i_wb_dat[1:0] == 2'b10);
                            wen_q[3] <= (i_wb_dat[1:0] == 2'b11) && fine_q;
                            state_q  <= L2_DEC;
                        end
                    end else if (i_wb_err || cnt_q == TMO_LAST) begin
                        cyc_q          <= 1'b0;
                        stb_q          <= 1'b0;
                        sel_q          <= '0;
                        fault_q        <= 1'b1;
                        far_q          <= va_q;
                        fsr_q          <= (state_q == L1_REQ) ? 8'h0C : {dac_q, 4'hE};
                        done_q[ch_q]   <= 1'b1;
                        state_q        <= DONE;
                    end
                end
                L1_DEC: begin
                    case (desc_q[1:0])
                        2'b10: begin
                            done_q[ch_q] <= 1'b1;
                            state_q      <= DONE;
                        end
                        2'b01: begin
                            adr_q   <= {desc_q[31:10], va_q[19:12], 2'b00};
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            sel_q   <= 4'hF;
                            cnt_q   <= '0;
                            state_q <= L2_REQ;
                        end
                        2'b11: begin
                            if (FINE_EN != 0) begin
                                adr_q   <= {desc_q[31:12], va_q[19:10], 2'b00};
                                cyc_q   <= 1'b1;
                                stb_q   <= 1'b1;
                                sel_q   <= 4'hF;
                                cnt_q   <= '0;
                                state_q <= L2_REQ;
                            end else begin
                                fault_q      <= 1'b1;
                                far_q        <= va_q;
                                fsr_q        <= {dac_q, 4'h5};
                                done_q[ch_q] <= 1'b1;
                                state_q      <= DONE;
                            end
                        end
                        default: begin
                            fault_q      <= 1'b1;
                            far_q        <= va_q;
                            fsr_q        <= {dac_q, 4'h5};
                            done_q[ch_q] <= 1'b1;
                            state_q      <= DONE;
                        end
                    endcase
                end
                L2_DEC: begin
                    // Invalid page, or a tiny page reached through a coarse table.
                    if (desc_q[1:0] == 2'b00 || (desc_q[1:0] == 2'b11 && !fine_q)) begin
                        fault_q <= 1'b1;
                        far_q   <= va_q;
                        fsr_q   <= {dac_q, 4'h7};
                    end
                    done_q[ch_q] <= 1'b1;
                    state_q      <= DONE;
                end
                DONE: begin
                    rr_q    <= (ch_q == CHW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_walk_done = done_q;
    assign o_fault     = fault_q;
    assign o_fsr       = fsr_q;
    assign o_far       = far_q;
    assign o_tlb_wen   = wen_q;
    assign o_tlb_ch    = ch_q;
    assign o_tlb_va    = va_q;
    assign o_tlb_desc  = desc_q;
    assign o_tlb_dac   = dac_q;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = stb_q;
    assign o_wb_wen    = 1'b0;
    assign o_wb_sel    = sel_q;
    assign o_wb_adr    = adr_q;
endmodule
